// File: rtl/mul_pkg.sv
// Shared encodings for the shift-add multiplier sequencer and the core's ALU decoder.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_NOP = 4'b1111;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Iterative shift-add MUL (low XLEN bits) that borrows the core ALU's ADD for
// every partial-product accumulation.
//
// state | meaning
// IDLE  | ready for a request; ALU released (NOP, operands 0)
// RUN   | one accumulate per cycle through the shared ALU
// DONE  | product presented, held until resp_ready
module alu_mul_sequencer
  import mul_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int CNT_W      = 7,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_multiplicand,
  input  logic [XLEN-1:0] req_multiplier,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_product,
  output logic            alu_busy,
  output logic [XLEN-1:0] alu_source_1,
  output logic [XLEN-1:0] alu_source_2,
  output logic [3:0]      alu_code,
  input  logic [XLEN-1:0] alu_result
);

  state_t            state;
  logic [XLEN-1:0]   acc;
  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   mplier;
  logic [CNT_W-1:0]  cnt;

  logic [XLEN-1:0]   mcand_sh;
  logic [XLEN-1:0]   mplier_sh;
  logic              last_iter;
  logic              zero_op;

  assign mcand_sh  = mcand << 1;
  assign mplier_sh = mplier >> 1;
  assign last_iter = (cnt == CNT_W'(XLEN - 1)) || (EARLY_EXIT && (mplier_sh == '0));
  assign zero_op   = (req_multiplicand == '0) || (req_multiplier == '0);

  // ALU operand outputs are registered one step ahead so that during RUN they
  // always equal the current acc and the gated current multiplicand.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      cnt          <= '0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_product <= '0;
      alu_busy     <= 1'b0;
      alu_source_1 <= '0;
      alu_source_2 <= '0;
      alu_code     <= ALU_NOP;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mcand     <= req_multiplicand;
            mplier    <= req_multiplier;
            acc       <= '0;
            cnt       <= '0;
            req_ready <= 1'b0;
            if (zero_op) begin
              state        <= DONE;
              resp_valid   <= 1'b1;
              resp_product <= '0;
            end else begin
              state        <= RUN;
              alu_busy     <= 1'b1;
              alu_code     <= ALU_ADD;
              alu_source_1 <= '0;
              alu_source_2 <= req_multiplier[0] ? req_multiplicand : '0;
            end
          end
        end
        RUN: begin
          acc    <= alu_result;
          mcand  <= mcand_sh;
          mplier <= mplier_sh;
          cnt    <= cnt + 1'b1;
          if (last_iter) begin
            state        <= DONE;
            resp_valid   <= 1'b1;
            resp_product <= alu_result;
            alu_busy     <= 1'b0;
            alu_code     <= ALU_NOP;
            alu_source_1 <= '0;
            alu_source_2 <= '0;
          end else begin
            alu_source_1 <= alu_result;
            alu_source_2 <= mplier_sh[0] ? mcand_sh : '0;
          end
        end
        DONE: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          alu_busy   <= 1'b0;
          alu_code   <= ALU_NOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer with a behavioural ALU in the loop.
module tb_alu_mul_sequencer;

  localparam int XLEN = 64;

  typedef struct {
    logic [XLEN-1:0] prod;
    int              iters;
    int              t;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [XLEN-1:0] req_multiplicand = '0;
  logic [XLEN-1:0] req_multiplier = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b1;
  logic [XLEN-1:0] resp_product;
  logic            alu_busy;
  logic [XLEN-1:0] alu_source_1, alu_source_2, alu_result;
  logic [3:0]      alu_code;

  // Second instance with EARLY_EXIT=0
  logic            req_valid0 = 1'b0;
  logic            req_ready0;
  logic            resp_valid0;
  logic [XLEN-1:0] resp_product0;
  logic            alu_busy0;
  logic [XLEN-1:0] alu_source_10, alu_source_20, alu_result0;
  logic [3:0]      alu_code0;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;
  bit   first = 1'b1;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [XLEN-1:0] alu_f(input logic [3:0] c, input logic [XLEN-1:0] a, b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a - b;
      default: return '0;
    endcase
  endfunction

  assign alu_result  = alu_f(alu_code, alu_source_1, alu_source_2);
  assign alu_result0 = alu_f(alu_code0, alu_source_10, alu_source_20);

  alu_mul_sequencer #(.XLEN(XLEN), .CNT_W(7), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_multiplicand(req_multiplicand), .req_multiplier(req_multiplier),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_product(resp_product),
    .alu_busy(alu_busy), .alu_source_1(alu_source_1), .alu_source_2(alu_source_2),
    .alu_code(alu_code), .alu_result(alu_result)
  );

  alu_mul_sequencer #(.XLEN(XLEN), .CNT_W(7), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0),
    .req_multiplicand(req_multiplicand), .req_multiplier(req_multiplier),
    .resp_valid(resp_valid0), .resp_ready(1'b1), .resp_product(resp_product0),
    .alu_busy(alu_busy0), .alu_source_1(alu_source_10), .alu_source_2(alu_source_20),
    .alu_code(alu_code0), .alu_result(alu_result0)
  );

  task automatic check(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compares every presented response against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (alu_busy) begin
        busy_cnt++;
        check("alu_code_run", {60'd0, alu_code}, 64'h2);
      end else begin
        check("alu_code_idle", {60'd0, alu_code}, 64'hF);
      end
      if (resp_valid) begin
        if (q.size() == 0) begin
          check("unexpected_resp", 64'd1, 64'd0);
        end else begin
          check("product", resp_product, q[0].prod);
          check("req_ready_in_done", {63'd0, req_ready}, 64'd0);
          if (first) begin
            check("latency", 64'(cyc - q[0].t), 64'(1 + q[0].iters));
            check("busy_cycles", 64'(busy_cnt), 64'(q[0].iters));
            first = 1'b0;
          end
          if (resp_ready) begin
            void'(q.pop_front());
            busy_cnt = 0;
            first    = 1'b1;
          end
        end
      end
    end
  end

  task automatic issue(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] p, input int n);
    int w;
    exp_t e;
    w = 0;
    @(posedge clk); #1;
    req_valid        = 1'b1;
    req_multiplicand = a;
    req_multiplier   = b;
    @(negedge clk);
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      check("req_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    e.prod = p; e.iters = n; e.t = cyc;
    q.push_back(e);
    @(posedge clk); #1;
    req_valid        = 1'b0;
    req_multiplicand = 64'hDEAD_BEEF_0BAD_F00D;
    req_multiplier   = 64'hFFFF_0000_FFFF_0000;
  endtask

  task automatic wait_empty();
    int w;
    w = 0;
    while (q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) begin
      check("resp_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  initial begin
    int n;
    int t0;
    int w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_product", resp_product, 64'd0);
    check("rst_busy", {63'd0, alu_busy}, 64'd0);
    check("rst_src1", alu_source_1, 64'd0);
    check("rst_src2", alu_source_2, 64'd0);
    check("rst_code", {60'd0, alu_code}, 64'hF);
    @(posedge clk); #1;
    reset = 1'b0;

    issue(64'd3, 64'd5, 64'd15, 3);
    wait_empty();
    issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 64'hFFFF_FFFF_FFFF_FFD6, 3);
    wait_empty();
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64);
    wait_empty();
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64);
    wait_empty();
    issue(64'h1234, 64'd0, 64'd0, 0);
    wait_empty();
    issue(64'd0, 64'd5, 64'd0, 0);
    wait_empty();
    issue(64'd12345, 64'd1, 64'd12345, 1);
    wait_empty();
    issue(64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 33);
    wait_empty();

    // Backpressure with a competing request held during DONE
    resp_ready = 1'b0;
    issue(64'd3, 64'd5, 64'd15, 3);
    req_valid        = 1'b1;
    req_multiplicand = 64'd7;
    req_multiplier   = 64'd9;
    w = 0;
    @(negedge clk);
    while (!resp_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("bp_resp_seen", {63'd0, resp_valid}, 64'd1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    issue(64'd7, 64'd9, 64'd63, 4);
    wait_empty();

    // Reset in the 10th RUN cycle of a 64-iteration multiply
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64);
    repeat (10) @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    busy_cnt = 0;
    first    = 1'b1;
    @(negedge clk);
    check("abort_req_ready", {63'd0, req_ready}, 64'd1);
    check("abort_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("abort_code", {60'd0, alu_code}, 64'hF);
    check("abort_busy", {63'd0, alu_busy}, 64'd0);
    issue(64'd2, 64'd2, 64'd4, 2);
    wait_empty();

    // EARLY_EXIT=0: always XLEN iterations
    @(posedge clk); #1;
    req_valid0       = 1'b1;
    req_multiplicand = 64'd5;
    req_multiplier   = 64'd3;
    @(negedge clk);
    check("ee0_ready", {63'd0, req_ready0}, 64'd1);
    t0 = cyc;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    n = 0;
    w = 0;
    @(negedge clk);
    while (!resp_valid0 && w < 200) begin
      if (alu_busy0) n++;
      @(negedge clk);
      w++;
    end
    check("ee0_resp_seen", {63'd0, resp_valid0}, 64'd1);
    check("ee0_latency", 64'(cyc - t0), 64'd65);
    check("ee0_busy", 64'(n), 64'd64);
    check("ee0_product", resp_product0, 64'd15);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Iterative shift-add multiplier controller that time-shares the core's existing 64-bit ALU to execute RISC-V MUL, returning the low 64 bits of the product.
- Sits beside the execute stage. While busy it owns the ALU inputs through the core's ALU operand mux, using ALU ADD (alu_code 4'b0010) for each partial-product accumulation.
- Valid/ready request and response handshakes, one clock domain.

Parameters:
- XLEN, 64, operand/result width; must match the ALU width.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN.
- EARLY_EXIT, 1, when 1 stop iterating once the remaining multiplier bits are all zero; when 0 always run XLEN iterations.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_multiplicand  input  XLEN  operand rs1, signed or unsigned.
- req_multiplier  input  XLEN  operand rs2, signed or unsigned.
- resp_valid  output  1  product valid (high only in DONE).
- resp_ready  input  1  consumer accepts the product.
- resp_product  output  XLEN  low XLEN bits of the product.
- alu_busy  output  1  high in RUN; the core steers the ALU operands from this block.
- alu_source_1  output  XLEN  ALU operand 1 (accumulator).
- alu_source_2  output  XLEN  ALU operand 2 (shifted multiplicand or 0).
- alu_code  output  4  ALU opcode.
- alu_result  input  XLEN  combinational ALU result for the current operands.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: state=IDLE; req_ready=1; resp_valid=0; resp_product=0; alu_busy=0; alu_source_1=0; alu_source_2=0; alu_code=4'b1111. Internal acc, mcand, mplier and cnt are cleared.
- Reset asserted mid-operation aborts it. The next cycle is IDLE with no response and no partial result visible.
- States: IDLE, RUN, DONE.
- IDLE:
  - Accept when req_valid&&req_ready. Latch mcand=req_multiplicand, mplier=req_multiplier, acc=0, cnt=0.
  - If either operand == 0: go to DONE with acc=0 and skip RUN entirely. resp_valid is high the cycle after accept.
  - Otherwise go to RUN.
- RUN (one iteration per cycle):
  - alu_code=4'b0010.
  - alu_source_1=acc.
  - alu_source_2=mplier[0] ? mcand : 0.
  - acc<=alu_result; mcand<=mcand<<1 (zero fill); mplier<=mplier>>1 (logical); cnt<=cnt+1.
  - Exit to DONE after the iteration where cnt==XLEN-1, or, if EARLY_EXIT, where (mplier>>1)==0.
- Iteration count with EARLY_EXIT: bit index of the highest set bit of the multiplier, plus 1. Range 1..64.
- Latency: accept at cycle T, resp_valid at T+1+iterations.
- DONE:
  - resp_valid=1; resp_product=acc, held stable.
  - On resp_valid&&resp_ready go to IDLE. req_ready rises the following cycle, so there is no same-cycle re-accept.
- Arithmetic:
  - All sums wrap modulo 2^XLEN; ALU overflow is ignored.
  - The low XLEN bits of a two's-complement product are identical for signed and unsigned operands, so no sign correction is needed.
- ALU outputs outside RUN: alu_code=4'b1111 (ALU default, result 0); alu_source_1=alu_source_2=0.
- req_valid while busy is ignored (req_ready=0). Operand inputs are sampled only at accept.

Decomposition:
- Shared package mul_pkg:
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - ALU opcode constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0011, ALU_NOP=4'b1111, so the core decoder uses the same values.
- No sub-module is needed.
- The bench instantiates the existing alu and connects alu_result back to this block.

Test Plan:
- 3 x 5: 3 iterations; resp_product=15 at T+4; alu_busy high exactly 3 cycles.
- -7 x 6 (0xFFFFFFFFFFFFFFF9 x 6): resp_product=0xFFFFFFFFFFFFFFD6 (-42) after 3 iterations.
- 0x8000000000000000 x 0xFFFFFFFFFFFFFFFF: 64 iterations; resp_product=0x8000000000000000. With EARLY_EXIT=0, 5 x 3 also takes 64 iterations and gives 15.
- Zero operand (0x1234 x 0): resp_valid at T+1 with product 0; alu_busy never asserted.
- Backpressure: resp_ready held low for 5 cycles in DONE. Product is held stable, req_ready=0, and a new req_valid is ignored; accepted one cycle after the resp handshake.
- Reset asserted at the 10th RUN cycle of a 64-iteration multiply: next cycle IDLE with req_ready=1, resp_valid=0, alu_code=4'b1111. A following 2 x 2 returns 4.
